noise_sched: RTL
================

Name: noise_sched

Overview:
Controller and scheduler for the DDS noise source. It owns a stepped/loadable 14-bit XNOR LFSR core and decides when it advances: either from a programmable clock divider or from the DDS phase-accumulator wrap pulse. It also handles seed loading and recovery from the lock-up state, and presents each new noise sample through a registered valid/ready output to the waveform mux.

Parameters:
N, 14, LFSR length (matches the phase accumulator width)
M, 12, noise sample width; sample = shift[N-1:N-M]
DIV_W, 8, width of the rate divider

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  run enable
sync_mode  in  1  1: step on phase_wrap; 0: step from the divider
rate  in  DIV_W  divider terminal count; step every rate+1 cycles
phase_wrap  in  1  one-cycle pulse on phase-accumulator wrap
seed_load  in  1  load-seed request (level-sampled)
seed  in  N  seed value
out_ready  in  1  consumer accepts the sample
out_valid  out  1  noise_out holds an unconsumed sample
noise_out  out  M  registered noise sample
overrun  out  1  sticky: a valid sample was overwritten before acceptance
lockup  out  1  sticky: the lock-up state was detected and recovered

Behaviour:
- Reset values: shift=0, noise_out=0, out_valid=0, overrun=0, lockup=0, divider cnt=0, step=0, state=IDLE.
- LFSR step: shift <= {shift[N-2:0], fb}, where fb = shift[N-1] XNOR shift[N-2] XNOR shift[N-3] XNOR shift[1]. Lock-up state is all-ones.
- States:
  - IDLE: LFSR holds; cnt=0; no steps. Moves to RUN when en=1.
  - RUN: generates steps (rules below). Moves to IDLE when en=0, which takes effect the same cycle with no further step.
  - LOAD: lasts one cycle. shift <= seed, except an all-ones seed is replaced by 0. cnt<=0, out_valid<=0. Next state is RUN if en, else IDLE.
  - RECOVER: lasts one cycle. shift<=0, lockup<=1. Next state is RUN.
- Priority per cycle: rst > seed_load (enters LOAD from any state) > lock-up detect (RUN with shift all-ones) > en.
- Divider (sync_mode=0, RUN):
  - If cnt >= rate: step pulse, cnt<=0.
  - Otherwise cnt<=cnt+1.
  - rate=0 steps every cycle.
  - A live change of rate below the current cnt forces an immediate step.
- Sync mode (sync_mode=1, RUN):
  - step = phase_wrap, and cnt is held at 0.
  - Switching sync_mode takes effect the next cycle.
- Latency:
  - The step pulse is registered. The LFSR advances on the edge where step=1.
  - On the following edge, noise_out <= shift[N-1:N-M] and out_valid<=1.
  - Step decision to out_valid is therefore 2 cycles.
- Handshake:
  - out_valid falls on the edge where out_valid & out_ready, unless a new sample captures on the same edge; then it stays 1 with the new data and no overrun.
  - A capture while out_valid=1 & out_ready=0 overwrites noise_out and sets overrun.
  - noise_out is stable while out_valid=1 & out_ready=0 and no capture occurs.
- Reset mid-operation clears everything to reset values, including any in-flight step/capture.
- seed_load during a pending capture cancels the capture.

Decomposition:
- Package noise_pkg:
  - state enum {IDLE, RUN, LOAD, RECOVER}
  - tap-position constants (N-1, N-2, N-3, 1)
  - LOCKUP constant (all-ones of N)
  - seed-sanitise function
- One sub-module, noise_lfsr_core (ports: clk, rst, step, load, load_val[N], shift[N]). It implements the XNOR step and synchronous load, with load winning over step.
- noise_sched contains the FSM, divider, step register, output register and handshake.

Test Plan:
- Reset, then seed_load with seed=0, en=1, sync_mode=0, rate=0, out_ready=1 -> shift after steps 1,2,3 = 0x0001, 0x0003, 0x0006; third captured noise_out=0x001; out_valid high every cycle after fill.
- rate=3, out_ready=1 -> step pulses exactly 4 cycles apart; each out_valid high exactly 2 cycles after its step decision; change rate to 1 while cnt=2 -> immediate step, then every 2 cycles.
- sync_mode=1, phase_wrap pulses at cycles 10 and 25 -> exactly two LFSR advances, out_valid rising at cycles 12 and 27; divider inactive.
- out_ready=0 held, rate=0 -> out_valid stays 1, overrun sets on second capture, noise_out tracks the latest sample; then raise out_ready with a capture on the same edge -> out_valid stays 1.
- seed_load seed=0x3FFF -> shift loads 0x0000, lockup stays 0; deposit shift=0x3FFF in RUN -> next cycle RECOVER, shift=0, lockup=1, RUN resumes.
- rst asserted mid-run with out_valid=1 -> next cycle all outputs 0, state IDLE; en=0 mid-run -> shift frozen, no further captures.

Source files
------------

// File: rtl/noise_pkg.sv
// Shared types and constants for the DDS noise source.
// LFSR geometry, scheduler states and seed sanitising.
package noise_pkg;

    localparam int N     = 14;
    localparam int M     = 12;
    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LOAD,
        RECOVER
    } state_t;

    localparam int TAP0 = N - 1;
    localparam int TAP1 = N - 2;
    localparam int TAP2 = N - 3;
    localparam int TAP3 = 1;

    localparam logic [N-1:0] LOCKUP = '1;

    // All-ones would park the XNOR LFSR forever.
    function automatic logic [N-1:0] sanitize(
        input logic [N-1:0] s
    );
        return (s == LOCKUP) ? '0 : s;
    endfunction

endpackage

// File: rtl/noise_sched_if.sv
// Valid/ready sample channel from the noise scheduler
// to the waveform mux.
interface noise_sched_if;
    import noise_pkg::*;

    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] noise_out;

    modport master (
        output out_valid,
        output noise_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  noise_out,
        output out_ready
    );

endinterface

// File: rtl/noise_lfsr_core.sv
// 14-bit XNOR LFSR with synchronous load.
// Load takes precedence over a step.
module noise_lfsr_core
    import noise_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] shift
);

    logic fb;

    assign fb = ~(shift[TAP0] ^ shift[TAP1]
                ^ shift[TAP2] ^ shift[TAP3]);

    always_ff @(posedge clk) begin
        if (rst) begin
            shift <= '0;
        end else if (load) begin
            shift <= load_val;
        end else if (step) begin
            shift <= {shift[N-2:0], fb};
        end
    end

endmodule

// File: rtl/noise_sched.sv
// Noise source scheduler: rate divider / phase-wrap sync,
// seed load, lock-up recovery and sample output register.
module noise_sched
    import noise_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_mode,
    input  logic [DIV_W-1:0] rate,
    input  logic             phase_wrap,
    input  logic             seed_load,
    input  logic [N-1:0]     seed,
    noise_sched_if.master    dout,
    output logic             overrun,
    output logic             lockup
);

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic             step;
    logic             cap;
    logic             valid_q;
    logic [M-1:0]     data_q;
    logic [N-1:0]     shift;
    logic             locked;
    logic             core_step;
    logic             core_load;
    logic [N-1:0]     core_val;

    assign locked    = (state == RUN) && (shift == LOCKUP);
    // A pending step is dropped if the run is interrupted.
    assign core_step = step && (state == RUN) && en
                       && !locked && !seed_load;
    assign core_load = (state == LOAD) || (state == RECOVER);
    assign core_val  = (state == LOAD) ? sanitize(seed) : '0;

    noise_lfsr_core u_core (
        .clk      (clk),
        .rst      (rst),
        .step     (core_step),
        .load     (core_load),
        .load_val (core_val),
        .shift    (shift)
    );

    assign dout.out_valid = valid_q;
    assign dout.noise_out = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            step    <= 1'b0;
            cap     <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            overrun <= 1'b0;
            lockup  <= 1'b0;
        end else if (seed_load) begin
            state <= LOAD;
            cnt   <= '0;
            step  <= 1'b0;
            cap   <= 1'b0;
        end else begin
            cap <= core_step;
            if (cap) begin
                data_q  <= shift[N-1 -: M];
                valid_q <= 1'b1;
                if (valid_q && !dout.out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (valid_q && dout.out_ready) begin
                valid_q <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    cnt  <= '0;
                    step <= 1'b0;
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (locked) begin
                        state <= RECOVER;
                        step  <= 1'b0;
                        cnt   <= '0;
                    end else if (!en) begin
                        state <= IDLE;
                        step  <= 1'b0;
                        cnt   <= '0;
                    end else if (sync_mode) begin
                        step <= phase_wrap;
                        cnt  <= '0;
                    end else if (cnt >= rate) begin
                        step <= 1'b1;
                        cnt  <= '0;
                    end else begin
                        step <= 1'b0;
                        cnt  <= cnt + 1'b1;
                    end
                end
                LOAD: begin
                    state   <= en ? RUN : IDLE;
                    cnt     <= '0;
                    step    <= 1'b0;
                    valid_q <= 1'b0;
                end
                RECOVER: begin
                    state  <= RUN;
                    step   <= 1'b0;
                    lockup <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
